// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl
// Sequential shift-and-add unsigned multiplier with a start/ready/busy/done
// handshake. One multiplier bit is consumed per clock, so an operation takes
// a fixed WIDTH cycles in STEP regardless of the operand values.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset, clears all state at once
//   start    request, accepted at an edge only while ready=1
//   abort    synchronous cancel, honoured only while busy=1
//   a, b     multiplicand / multiplier, captured on the accepting edge
//   ready    high in IDLE or DONE (a start would be accepted)
//   busy     high while stepping
//   done     one-cycle pulse, product holds the new result
//   product  registered 2*WIDTH-bit result, holds the last completed product
module mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   shifted;

  // Next-state and datapath. acc's top bit is always zero between steps
  // (the shift refills it with 0), so adding the full acc is the same as
  // adding its low WIDTH bits and the sum never exceeds WIDTH+1 bits.
  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    sum     = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    shifted = {sum, mplier_q} >> 1;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = CW'(WIDTH);
          state_d  = STEP;
        end else begin
          state_d = IDLE;
        end
      end
      STEP: begin
        // Abort wins over completion on the same edge; product is untouched.
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d    = shifted[2*WIDTH:WIDTH];
          mplier_d = shifted[WIDTH-1:0];
          cnt_d    = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            product_d = shifted[2*WIDTH-1:0];
            state_d   = DONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Handshake outputs decode the state register only, so there is no
  // combinational path from any input to any output.
  assign ready   = (state_q == IDLE) || (state_q == DONE);
  assign busy    = (state_q == STEP);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule
